imem_loader: RTL and testbench

Programs the instruction memory ahead of execution and holds the pipelined core until the program is valid. It is the write side of the instruction fetch path: it accepts a byte stream over a valid/ready handshake, assembles 19-bit instruction words, and writes them to consecutive addresses from 0. It then checks a trailing XOR checksum and releases the core only if the check passes.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/loader_word_assembler.sv | 76 +++++++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
//   - state_e        : loader FSM state encoding
//   - INSTRUCTION_LEN: instruction word width
//   - ADDRESS_LEN    : instruction address width
//   - HDR_RSVD_BITS  : reserved upper bits of the 16-bit word-count header
//   - BYTES_PER_WORD : stream bytes per instruction word
`timescale 1ns/1ps
package imem_loader_pkg;

  localparam int unsigned INSTRUCTION_LEN = 19;
  localparam int unsigned ADDRESS_LEN     = 12;
  localparam int unsigned HDR_RSVD_BITS   = 4;
  localparam int unsigned BYTES_PER_WORD  = 3;
  localparam int unsigned BYTE_SEL_W      = $clog2(BYTES_PER_WORD);

  typedef enum logic [3:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StB0,
    StB1,
    StB2,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Assembles three little-endian stream bytes into one instruction word and keeps
// the running XOR checksum over all word bytes of a session.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : start of a session, zeroes the checksum
//   byte_en_i     : a word byte is accepted this cycle
//   byte_sel_i    : which byte of the word (0 = b0, 1 = b1, 2 = b2)
//   byte_i        : stream byte
//   word_o        : last completed word {b2[2:0], b1, b0}
//   csum_o        : XOR of all word bytes accepted since clear_i
//   rsvd_err_o    : byte_i has non-zero bits above the word width (valid for b2)
`timescale 1ns/1ps
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       byte_en_i,
  input  logic [BYTE_SEL_W-1:0]      byte_sel_i,
  input  logic [7:0]                 byte_i,
  output logic [INSTRUCTION_LEN-1:0] word_o,
  output logic [7:0]                 csum_o,
  output logic                       rsvd_err_o
);

  localparam int unsigned TopBits = INSTRUCTION_LEN - 16;

  logic [7:0]                 b0_q, b0_d;
  logic [7:0]                 b1_q, b1_d;
  logic [INSTRUCTION_LEN-1:0] word_q, word_d;
  logic [7:0]                 csum_q, csum_d;

  assign rsvd_err_o = (byte_i[7:TopBits] != '0);

  always_comb begin
    b0_d   = b0_q;
    b1_d   = b1_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      csum_d = 8'h00;
    end else if (byte_en_i) begin
      csum_d = csum_q ^ byte_i;
      unique case (byte_sel_i)
        2'd0: b0_d = byte_i;
        2'd1: b1_d = byte_i;
        2'd2: begin
          // A bad b2 sends the FSM to ERR; keep the old word on the data bus.
          if (!rsvd_err_o) begin
            word_d = {byte_i[TopBits-1:0], b1_q, b0_q};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b0_q   <= 8'h00;
      b1_q   <= 8'h00;
      word_q <= '0;
      csum_q <= 8'h00;
    end else begin
      b0_q   <= b0_d;
      b1_q   <= b1_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word_o = word_q;
  assign csum_o = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a byte stream (16-bit word-count header,
// N 3-byte words, XOR checksum byte), writes words to consecutive addresses from 0,
// and keeps the core held until a load completes with a matching checksum.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a session (honoured only in IDLE, DONE, ERR)
//   byte_valid/data     : stream input; byte_ready is the loader's acceptance
//   im_write_en/addr/data : single-cycle instruction memory write
//   core_hold           : holds the core in reset until a successful load
//   busy, done, error   : session in progress, success pulse, sticky failure
`timescale 1ns/1ps
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic                       im_write_en,
  output logic [ADDRESS_LEN-1:0]     im_write_addr,
  output logic [INSTRUCTION_LEN-1:0] im_write_data,
  output logic                       core_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  state_e                 state_q, state_d;
  logic [7:0]             hdr_lo_q, hdr_lo_d;
  logic [ADDRESS_LEN-1:0] words_left_q, words_left_d;
  logic [ADDRESS_LEN-1:0] addr_q, addr_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;

  logic                       accept;
  logic                       hdr_rsvd_err;
  logic [ADDRESS_LEN-1:0]     hdr_count;
  logic                       asm_clear;
  logic                       asm_en;
  logic [BYTE_SEL_W-1:0]      asm_sel;
  logic [INSTRUCTION_LEN-1:0] asm_word;
  logic [7:0]                 asm_csum;
  logic                       asm_rsvd_err;

  always_comb begin
    byte_ready = 1'b0;
    unique case (state_q)
      StHdrLo, StHdrHi, StB0, StB1, StB2, StCsum: byte_ready = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  assign accept       = byte_valid && byte_ready;
  assign hdr_rsvd_err = (byte_data[7 -: HDR_RSVD_BITS] != '0);
  assign hdr_count    = {byte_data[7-HDR_RSVD_BITS:0], hdr_lo_q};

  always_comb begin
    state_d      = state_q;
    hdr_lo_d     = hdr_lo_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    done_d       = 1'b0;
    asm_clear    = 1'b0;
    asm_en       = 1'b0;
    asm_sel      = '0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d   = StHdrLo;
          addr_d    = '0;
          hold_d    = 1'b1;
          asm_clear = 1'b1;
        end
      end
      StHdrLo: begin
        if (accept) begin
          hdr_lo_d = byte_data;
          state_d  = StHdrHi;
        end
      end
      StHdrHi: begin
        if (accept) begin
          if (hdr_rsvd_err) begin
            state_d = StErr;
          end else if (hdr_count == '0) begin
            state_d = StCsum;
          end else begin
            words_left_d = hdr_count;
            state_d      = StB0;
          end
        end
      end
      StB0: begin
        if (accept) begin
          asm_en  = 1'b1;
          asm_sel = BYTE_SEL_W'(0);
          state_d = StB1;
        end
      end
      StB1: begin
        if (accept) begin
          asm_en  = 1'b1;
          asm_sel = BYTE_SEL_W'(1);
          state_d = StB2;
        end
      end
      StB2: begin
        if (accept) begin
          asm_en  = 1'b1;
          asm_sel = BYTE_SEL_W'(2);
          state_d = asm_rsvd_err ? StErr : StWrite;
        end
      end
      StWrite: begin
        // The write strobe uses addr_q this cycle; the increment lands at the edge.
        addr_d       = addr_q + ADDRESS_LEN'(1);
        words_left_d = words_left_q - ADDRESS_LEN'(1);
        state_d      = (words_left_q == ADDRESS_LEN'(1)) ? StCsum : StB0;
      end
      StCsum: begin
        if (accept) begin
          if (byte_data == asm_csum) begin
            state_d = StDone;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hdr_lo_q     <= 8'h00;
      words_left_q <= '0;
      addr_q       <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_lo_q     <= hdr_lo_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
    end
  end

  loader_word_assembler u_asm (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clear_i    (asm_clear),
    .byte_en_i  (asm_en),
    .byte_sel_i (asm_sel),
    .byte_i     (byte_data),
    .word_o     (asm_word),
    .csum_o     (asm_csum),
    .rsvd_err_o (asm_rsvd_err)
  );

  // Decoded from state so an asynchronous reset drops the strobe immediately.
  assign im_write_en   = (state_q == StWrite);
  assign im_write_addr = addr_q;
  assign im_write_data = asm_word;
  assign core_hold     = hold_q;
  assign busy          = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign done          = done_q;
  assign error         = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        im_write_en;
  logic [11:0] im_write_addr;
  logic [18:0] im_write_data;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .im_write_en   (im_write_en),
    .im_write_addr (im_write_addr),
    .im_write_data (im_write_data),
    .core_hold     (core_hold),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write / done monitor
  logic [30:0] got_w[$];
  int          bad_strobe = 0;
  int          done_cnt = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (im_write_en) begin
      got_w.push_back({im_write_addr, im_write_data});
      if (prev_we || byte_ready) bad_strobe++;
    end
    prev_we = im_write_en;
    if (done) done_cnt++;
  end

  // Reference model: parse the stream by the format rules
  logic [7:0]  stream[$];
  logic [30:0] exp_w[$];
  bit          exp_ok;

  task automatic model();
    int n;
    int idx;
    logic [7:0]  x, b0, b1, b2;
    logic [15:0] hdr;
    exp_w.delete();
    exp_ok = 1'b0;
    if (stream.size() < 2) return;
    hdr = {stream[1], stream[0]};
    if (hdr[15:12] != 4'h0) return;
    n = int'(hdr[11:0]);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      idx = 2 + 3 * i;
      if (idx + 2 >= stream.size()) return;
      b0 = stream[idx];
      b1 = stream[idx + 1];
      b2 = stream[idx + 2];
      if (b2[7:3] != 5'd0) return;
      x = x ^ b0 ^ b1 ^ b2;
      exp_w.push_back({12'(i), b2[2:0], b1, b0});
    end
    if (2 + 3 * n >= stream.size()) return;
    exp_ok = (stream[2 + 3 * n] == x);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit xfer);
    bit hit;
    hit = 1'b0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 40; t++) begin
      if (hit || !busy) break;
      if (byte_ready) begin
        @(posedge clk);
        hit = 1'b1;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("xfer_or_ended", hit || !busy, 1);
    xfer = hit;
  endtask

  task automatic run_session(input string tag, input bit gaps);
    bit x;
    bit all_x;
    model();
    got_w.delete();
    done_cnt   = 0;
    bad_strobe = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready_after_start"}, byte_ready, 1);
    check({tag, "_err_cleared"}, error, 0);
    check({tag, "_hold_set"}, core_hold, 1);
    all_x = 1'b1;
    foreach (stream[i]) begin
      if (all_x) begin
        send_byte(stream[i], gaps, x);
        if (!x) all_x = 1'b0;
      end
    end
    if (all_x) begin
      check({tag, "_done_k1"}, done, exp_ok);
      check({tag, "_error_k1"}, error, !exp_ok);
    end
    repeat (3) @(negedge clk);
    check({tag, "_error"}, error, !exp_ok);
    check({tag, "_core_hold"}, core_hold, !exp_ok);
    check({tag, "_done_pulses"}, done_cnt, exp_ok);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_n_writes"}, got_w.size(), exp_w.size());
    check({tag, "_strobe"}, bad_strobe, 0);
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < got_w.size()) check({tag, "_write"}, got_w[i], exp_w[i]);
    end
  endtask

  task automatic build_random(input int n, input int corrupt, input bit bad_b2);
    logic [7:0] x, b0, b1, b2;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back({4'h0, n[11:8]});
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom_range(0, 7));
      if (bad_b2 && i == n - 1) b2 = b2 | 8'h08;
      x = x ^ b0 ^ b1 ^ b2;
      stream.push_back(b0);
      stream.push_back(b1);
      stream.push_back(b2);
    end
    stream.push_back(corrupt != 0 ? (x ^ 8'(corrupt)) : x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_we", im_write_en, 0);
    check("rst_addr", im_write_addr, 0);
    check("rst_data", im_write_data, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ready", byte_ready, 0);
    check("idle_hold", core_hold, 1);

    // Single word
    stream = '{8'h01, 8'h00, 8'h45, 8'h23, 8'h01, 8'h67};
    run_session("single", 1'b0);
    check("single_exact", got_w.size() == 1 ? got_w[0] : 31'h0, {12'h000, 19'h12345});

    // Three words, gapped
    build_random(3, 0, 1'b0);
    run_session("three_gapped", 1'b1);

    // Bad checksum, then the next start must clear error
    stream = '{8'h01, 8'h00, 8'h45, 8'h23, 8'h01, 8'h66};
    run_session("bad_csum", 1'b0);

    // Reserved header bits
    stream = '{8'h00, 8'h10};
    run_session("hdr_rsvd", 1'b0);

    // Reserved b2 bits
    stream = '{8'h01, 8'h00, 8'h45, 8'h23, 8'h08, 8'h6e};
    run_session("b2_rsvd", 1'b0);

    // Empty program
    stream = '{8'h00, 8'h00, 8'h00};
    run_session("n_zero", 1'b0);

    // Randomized sessions
    for (int s = 0; s < 8; s++) begin
      int r;
      r = int'($urandom_range(0, 7));
      build_random(int'($urandom_range(1, 6)), (r == 0) ? int'($urandom_range(1, 255)) : 0,
                   r == 1);
      run_session("random", 1'b1);
    end

    // Good load so core_hold is low, then reset during b1 of word 2
    build_random(1, 0, 1'b0);
    run_session("pre_reset", 1'b0);
    build_random(2, 0, 1'b0);
    got_w.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0, x);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", byte_ready, 0);
    check("mid_rst_hold", core_hold, 1);
    check("mid_rst_we", im_write_en, 0);
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h05;
    repeat (6) @(negedge clk);
    check("post_rst_ready", byte_ready, 0);
    byte_valid = 1'b0;
    check("post_rst_writes", got_w.size(), 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_hold", core_hold, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
